// File: rtl/cla_64bit.sv
// cla_64bit -- 64-bit unsigned carry-lookahead adder with a registered result.
//
// Computes {cout,sum} = a + b + cin (exact 65-bit result, modulo 2^64 on sum).
// The carry network has three lookahead levels: 16 four-bit groups, 4 blocks
// of 16 bits, and one top unit over the 4 blocks. No carry ripples anywhere.
//
// Ports:
//   CLK    in   1   clock, rising-edge active
//   reset  in   1   asynchronous, active-high reset
//   a      in   64  operand A, unsigned
//   b      in   64  operand B, unsigned
//   cin    in   1   carry into bit 0
//   sum    out  64  registered sum
//   cout   out  1   registered carry out of bit 63
//
// Configuration macro:
//   CLA_64BIT_INREG_EN  when defined, a/b/cin are registered before the
//                       lookahead network (latency 2 instead of 1).

module cla_64bit (
  input  logic        CLK,
  input  logic        reset,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        op_cin;

`ifdef CLA_64BIT_INREG_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
    end else begin
      op_a   <= a;
      op_b   <= b;
      op_cin <= cin;
    end
  end
`else
  assign op_a   = a;
  assign op_b   = b;
  assign op_cin = cin;
`endif

  // Group generate/propagate over four (g,p) pairs: returns {gg, gp}.
  function automatic logic [1:0] gen_prop4(input logic [3:0] gi, input logic [3:0] pi);
    logic gg;
    logic gp;
    gg = gi[3]
       | (pi[3] & gi[2])
       | (pi[3] & pi[2] & gi[1])
       | (pi[3] & pi[2] & pi[1] & gi[0]);
    gp = &pi;
    return {gg, gp};
  endfunction

  // Carries into the four positions of a group, flattened sum-of-products
  // from the group carry-in: returns {c3, c2, c1, c0}.
  function automatic logic [3:0] carry4(input logic [3:0] gi, input logic [3:0] pi,
                                        input logic c0);
    logic c1;
    logic c2;
    logic c3;
    c1 = gi[0] | (pi[0] & c0);
    c2 = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c0);
    c3 = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
       | (pi[2] & pi[1] & pi[0] & c0);
    return {c3, c2, c1, c0};
  endfunction

  logic [63:0] g;
  logic [63:0] p;
  logic [63:0] c;
  logic [15:0] grp_g;
  logic [15:0] grp_p;
  logic [15:0] grp_c;
  logic [3:0]  blk_g;
  logic [3:0]  blk_p;
  logic [3:0]  blk_c;
  logic        top_g;
  logic        top_p;
  logic        c64;
  logic [63:0] comb_sum;

  assign g = op_a & op_b;
  assign p = op_a ^ op_b;

  // Level 1: group generate/propagate from bit signals.
  always_comb begin
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < 16; k++) begin
      {grp_g[k], grp_p[k]} = gen_prop4(g[4*k +: 4], p[4*k +: 4]);
    end
  end

  // Level 2: 16-bit block generate/propagate from group signals.
  always_comb begin
    blk_g = '0;
    blk_p = '0;
    for (int j = 0; j < 4; j++) begin
      {blk_g[j], blk_p[j]} = gen_prop4(grp_g[4*j +: 4], grp_p[4*j +: 4]);
    end
  end

  // Level 3: block carry-ins and the final carry, all straight from cin.
  always_comb begin
    blk_c          = carry4(blk_g, blk_p, op_cin);
    {top_g, top_p} = gen_prop4(blk_g, blk_p);
  end

  assign c64 = top_g | (top_p & op_cin);

  // Carries flow back down: block carry-in -> group carry-ins -> bit carries.
  always_comb begin
    grp_c = '0;
    for (int j = 0; j < 4; j++) begin
      grp_c[4*j +: 4] = carry4(grp_g[4*j +: 4], grp_p[4*j +: 4], blk_c[j]);
    end
  end

  always_comb begin
    c = '0;
    for (int k = 0; k < 16; k++) begin
      c[4*k +: 4] = carry4(g[4*k +: 4], p[4*k +: 4], grp_c[k]);
    end
  end

  assign comb_sum = p ^ c;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= comb_sum;
      cout <= c64;
    end
  end

endmodule

// File: tb/tb_cla_64bit.sv
// tb_cla_64bit -- directed self-checking bench for cla_64bit.
//
// Expected results come from a plain 65-bit addition done in the bench.
// Latency follows the CLA_64BIT_INREG_EN build option (1 or 2 cycles).

module tb_cla_64bit;

`ifdef CLA_64BIT_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK;
  logic        reset;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [63:0] sum;
  logic        cout;

  int vectors;
  int miscompares;

  cla_64bit dut (
    .CLK   (CLK),
    .reset (reset),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [64:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic ci);
    return {1'b0, x} + {1'b0, y} + {64'd0, ci};
  endfunction

  task automatic check(input string tag, input logic [64:0] expected);
    vectors++;
    assert ({cout, sum} === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, {cout, sum}, expected);
    end
  endtask

  task automatic apply(input string tag, input logic [63:0] x, input logic [63:0] y,
                       input logic ci, input logic [64:0] expected);
    @(negedge CLK);
    a   = x;
    b   = y;
    cin = ci;
    repeat (LAT) @(posedge CLK);
    #1;
    check(tag, expected);
  endtask

  logic [63:0] ra;
  logic [63:0] rb;
  logic        rc;
  logic [64:0] stream_exp [8];

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #1;
    check("reset_at_time0", 65'd0);

    @(negedge CLK);
    reset = 1'b0;

    apply("small_add", 64'd5, 64'd3, 1'b0, 65'd8);

    // Async reset: result must clear immediately, well before the next edge.
    reset = 1'b1;
    #1;
    check("async_reset_clears", 65'd0);
    @(negedge CLK);
    reset = 1'b0;

    apply("all_ones_plus_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1,
          {1'b1, 64'd0});
    apply("all_ones_twice_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
          {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
    apply("msb_plus_msb", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
          {1'b1, 64'd0});
    apply("block_carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
          {1'b0, 64'h0000_0001_0000_0000});
    apply("zero_add", 64'd0, 64'd0, 1'b0, 65'd0);
    apply("group_carry", 64'h0000_0000_0000_FFFF, 64'd0, 1'b1,
          {1'b0, 64'h0000_0000_0001_0000});
    apply("alternating", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1,
          {1'b1, 64'd0});
    apply("upper_block_carry", 64'hFFFF_0000_0000_0000, 64'h0001_0000_0000_0000, 1'b0,
          {1'b1, 64'd0});

    // Back-to-back operands, one per cycle.
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      stream_exp[i] = model(ra, rb, rc);
      @(negedge CLK);
      a   = ra;
      b   = rb;
      cin = rc;
      @(posedge CLK);
      #1;
      if (i >= LAT - 1) check("stream", stream_exp[i - (LAT - 1)]);
    end
    for (int i = 8 - (LAT - 1); i < 8; i++) begin
      @(posedge CLK);
      #1;
      check("stream_drain", stream_exp[i]);
    end

    // Random vectors with a reset between each.
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      reset = 1'b1;
      #1;
      check("rand_reset", 65'd0);
      @(negedge CLK);
      reset = 1'b0;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      apply("random", ra, rb, rc, model(ra, rb, rc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
